wb_sram_slave: RTL and testbench
================================

Name: wb_sram_slave

Overview:
- Wishbone classic, pipeline-free slave that turns bus cycles from the CPU data-side master into timed accesses to an external asynchronous 32-bit SRAM.
- Sits on the system bus behind the interconnect, serving data-cache refills and write-throughs.
- Adds programmable read and write wait states and a registered one-cycle acknowledge.
- Exposes split tri-state data signals for the top-level pad wrapper.

Parameters:
- ADDR_WIDTH, 20, SRAM word-address width; SRAM size is 4*2^ADDR_WIDTH bytes.
- RD_WAIT, 2, cycles the read strobe is held before data is sampled; minimum 1.
- WR_WAIT, 2, cycles sram_we_n is held low; minimum 1.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; asynchronous, active-high.
- wb_cyc_i  in  1  bus cycle valid.
- wb_stb_i  in  1  strobe.
- wb_we_i  in  1  1 = write.
- wb_adr_i  in  32  byte address.
- wb_dat_i  in  32  write data.
- wb_sel_i  in  4  byte lanes.
- wb_dat_o  out  32  read data, registered.
- wb_ack_o  out  1  transfer done, one-cycle pulse.
- wb_err_o  out  1  error response.
- wb_rty_o  out  1  retry; tied 0.
- sram_addr  out  ADDR_WIDTH  word address.
- sram_data_o  out  32  data driven to pads.
- sram_data_i  in  32  data from pads.
- sram_data_t  out  1  1 = pads are high-Z (input).
- sram_ce_n  out  1  chip enable, active-low.
- sram_oe_n  out  1  output enable, active-low.
- sram_we_n  out  1  write enable, active-low.
- sram_be_n  out  4  byte enables, active-low.

Behaviour:
- Reset: on rst, state = IDLE immediately (asynchronously), including mid-transaction.
  - Reset values: wb_ack_o=0, wb_err_o=0, wb_dat_o=0, sram_ce_n=1, sram_oe_n=1, sram_we_n=1, sram_be_n=4'hF, sram_data_t=1, sram_addr=0, sram_data_o=0.
- Outputs: all outputs are driven from registers, so there are no combinational paths from bus inputs to outputs.
- Request: wb_cyc_i & wb_stb_i sampled high in IDLE. On the same edge the block latches:
  - sram_addr <= wb_adr_i[ADDR_WIDTH+1:2]; wb_adr_i[1:0] are ignored.
  - Write data and byte lanes.
- State machine:
  - IDLE: on a read request -> READ; on a write request -> WR_SETUP.
  - READ: held for RD_WAIT cycles with ce_n=0, oe_n=0, be_n=0000, data_t=1. On the last cycle's edge, wb_dat_o <= sram_data_i, then -> DONE.
  - WR_SETUP: 1 cycle with ce_n=0, we_n=1, data_t=0, data_o=wb_dat_i, be_n=~wb_sel_i. Then -> WR_PULSE.
  - WR_PULSE: WR_WAIT cycles with we_n=0; address, data and be_n stable. Then -> WR_HOLD.
  - WR_HOLD: 1 cycle with we_n=1; data is still driven. Then -> DONE.
  - DONE: wb_ack_o=1 for this single cycle; ce_n=1, data_t=1. Then -> IDLE.
- Latency, counting the request cycle as cycle 0:
  - Read: ack in cycle RD_WAIT+1.
  - Write: ack in cycle WR_WAIT+3.
- wb_dat_o holds its last read value until the next read completes; writes do not change it.
- Wait counter: down-counter loaded with RD_WAIT-1 or WR_WAIT-1 on state entry, width $clog2(max(RD_WAIT,WR_WAIT))+1. The state exits when the counter reaches 0.
- Back-to-back: if stb/cyc are still high in the IDLE cycle after DONE, the block starts a new transaction. The minimum gap between acks is therefore 1 idle cycle.
- Abort (wb_cyc_i drops before ack):
  - In READ: -> IDLE on the next edge, no ack, ce_n/oe_n high.
  - In WR_SETUP: -> IDLE, we_n never asserted.
  - In WR_PULSE or WR_HOLD: the write completes through WR_HOLD, then -> IDLE with no ack, so no truncated write pulse reaches the SRAM.
- Bus contention: sram_data_t is 1 whenever oe_n=0, and oe_n is 1 whenever data_t=0.
- wb_sel_i=0000 on a write: the full sequence runs with be_n=1111 and is acked.

Optional Feature:
- Macro: WB_SRAM_ADDR_CHECK_EN.
- Defined: a request with any of wb_adr_i[31:ADDR_WIDTH+2] nonzero goes IDLE -> ERR.
  - ERR pulses wb_err_o for 1 cycle in cycle 1, with no SRAM strobes and no ack.
  - Then -> IDLE.
- Undefined: upper address bits are ignored, so the SRAM aliases across the address space. wb_err_o is tied 0 and the ERR state does not exist.

Test Plan:
- Reset: assert rst mid-WR_PULSE -> we_n=1, ce_n=1, data_t=1, ack=0 in the same cycle; outputs hold their reset values until the next request.
- Word write (RD_WAIT=2, WR_WAIT=2): adr 0x0000_0010, dat 0xDEADBEEF, sel 1111 ->
  - sram_addr=4, be_n=0000;
  - we_n low for exactly 2 cycles (cycles 2-3);
  - single-cycle ack in cycle 5.
- Word read: adr 0x10 with the SRAM model holding 0xDEADBEEF -> oe_n low in cycles 1-2; ack in cycle 3 with wb_dat_o=0xDEADBEEF.
- Byte write: adr 0x12, sel 0100, dat 0x00AB0000 -> be_n=1011; a subsequent read of 0x10 returns 0xDEABBEEF.
- Abort: cyc dropped in READ cycle 1 -> no ack, ce_n=1 next cycle. An immediately following write to 0x20 completes normally with ack in cycle 5.
- With WB_SRAM_ADDR_CHECK_EN: read of 0x0040_0000 (ADDR_WIDTH=20) -> wb_err_o=1 in cycle 1 only, ce_n stays 1, no ack. Without the macro: same access -> SRAM word 0 is read and acked.

Source files
------------

// File: rtl/wb_sram_slave.sv
`default_nettype none
// ============================================================================
//  Module   : wb_sram_slave
//  Purpose  : Wishbone classic slave bridging single bus cycles to a 32-bit
//             asynchronous SRAM. Read and write wait states are set by
//             parameters. The acknowledge is registered and lasts one cycle.
//             The pad data bus is split into out / in / tri-state enable.
//  Options  : WB_SRAM_ADDR_CHECK_EN - when defined, a request with nonzero
//             address bits above the SRAM range gets a one-cycle wb_err_o
//             instead of an SRAM access. When undefined, those bits are
//             ignored and the SRAM aliases across the address space.
//  Ports    : clk, rst (async, active-high)
//             wb_*      - Wishbone slave side (cyc/stb/we/adr/dat/sel in;
//                         dat/ack/err/rty out)
//             sram_*    - SRAM pins: word address, split data bus, active-low
//                         ce/oe/we/be strobes
//  Revision : 1.0 - initial release
// ============================================================================
module wb_sram_slave #(
    parameter int ADDR_WIDTH = 20,
    parameter int RD_WAIT    = 2,
    parameter int WR_WAIT    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wb_cyc_i,
    input  logic                  wb_stb_i,
    input  logic                  wb_we_i,
    input  logic [31:0]           wb_adr_i,
    input  logic [31:0]           wb_dat_i,
    input  logic [3:0]            wb_sel_i,
    output logic [31:0]           wb_dat_o,
    output logic                  wb_ack_o,
    output logic                  wb_err_o,
    output logic                  wb_rty_o,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    output logic [31:0]           sram_data_o,
    input  logic [31:0]           sram_data_i,
    output logic                  sram_data_t,
    output logic                  sram_ce_n,
    output logic                  sram_oe_n,
    output logic                  sram_we_n,
    output logic [3:0]            sram_be_n
);

    localparam int c_MAX_WAIT = (RD_WAIT > WR_WAIT) ? RD_WAIT : WR_WAIT;
    localparam int CNT_W      = $clog2(c_MAX_WAIT) + 1;
    localparam logic [CNT_W-1:0] c_RD_LOAD = CNT_W'(RD_WAIT - 1);
    localparam logic [CNT_W-1:0] c_WR_LOAD = CNT_W'(WR_WAIT - 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_READ     = 3'd1,
        S_WR_SETUP = 3'd2,
        S_WR_PULSE = 3'd3,
        S_WR_HOLD  = 3'd4,
        S_DONE     = 3'd5
`ifdef WB_SRAM_ADDR_CHECK_EN
        , S_ERR    = 3'd6
`endif
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic               r_abort;
    logic               w_abort_nxt;
    logic               w_req;
    logic               w_adr_bad;

    logic               w_start_rd;
    logic               w_start_wr;
    logic               w_sram_act;
    logic               w_wr_phase;
    logic               w_rd_done;

    logic [31:0]           r_dat_o;
    logic                  r_ack;
    logic                  r_err;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [31:0]           r_data_o;
    logic                  r_data_t;
    logic                  r_ce_n;
    logic                  r_oe_n;
    logic                  r_we_n;
    logic [3:0]            r_be_n;

    // Address bits outside the SRAM word range never reach the pads.
    logic w_unused;
    assign w_unused = ^{wb_adr_i[31:ADDR_WIDTH+2], wb_adr_i[1:0]};

    assign w_req = wb_cyc_i & wb_stb_i;

`ifdef WB_SRAM_ADDR_CHECK_EN
    assign w_adr_bad = |wb_adr_i[31:ADDR_WIDTH+2];
`else
    assign w_adr_bad = 1'b0;
`endif

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_abort <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_abort <= w_abort_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_abort_nxt = r_abort;
        case (r_state)
            S_IDLE: begin
                w_abort_nxt = 1'b0;
                if (w_req) begin
                    if (w_adr_bad) begin
`ifdef WB_SRAM_ADDR_CHECK_EN
                        w_state_nxt = S_ERR;
`endif
                    end else if (wb_we_i) begin
                        w_state_nxt = S_WR_SETUP;
                    end else begin
                        w_state_nxt = S_READ;
                        w_cnt_nxt   = c_RD_LOAD;
                    end
                end
            end
            S_READ: begin
                if (!wb_cyc_i) begin
                    w_state_nxt = S_IDLE;
                end else if (r_cnt == '0) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            S_WR_SETUP: begin
                // Nothing has been strobed yet, so an abort can leave cleanly.
                if (!wb_cyc_i) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_WR_PULSE;
                    w_cnt_nxt   = c_WR_LOAD;
                end
            end
            S_WR_PULSE: begin
                // A started write pulse always runs to full length; the abort
                // is remembered and only suppresses the acknowledge.
                if (!wb_cyc_i) begin
                    w_abort_nxt = 1'b1;
                end
                if (r_cnt == '0) begin
                    w_state_nxt = S_WR_HOLD;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            S_WR_HOLD: begin
                if (r_abort || !wb_cyc_i) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
`ifdef WB_SRAM_ADDR_CHECK_EN
            S_ERR: begin
                w_state_nxt = S_IDLE;
            end
`endif
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output decode. Pin values are a function of the state being entered
    // and are registered, so every output changes together with the state
    // and nothing combinational reaches the pads or the bus.
    // ------------------------------------------------------------------
    always_comb begin
        w_start_rd = (r_state == S_IDLE) && (w_state_nxt == S_READ);
        w_start_wr = (r_state == S_IDLE) && (w_state_nxt == S_WR_SETUP);
        w_wr_phase = (w_state_nxt == S_WR_SETUP) || (w_state_nxt == S_WR_PULSE) ||
                     (w_state_nxt == S_WR_HOLD);
        w_sram_act = w_wr_phase || (w_state_nxt == S_READ);
        w_rd_done  = (r_state == S_READ) && (w_state_nxt == S_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dat_o  <= '0;
            r_ack    <= 1'b0;
            r_err    <= 1'b0;
            r_addr   <= '0;
            r_data_o <= '0;
            r_data_t <= 1'b1;
            r_ce_n   <= 1'b1;
            r_oe_n   <= 1'b1;
            r_we_n   <= 1'b1;
            r_be_n   <= 4'hF;
        end else begin
            r_ack    <= (w_state_nxt == S_DONE);
`ifdef WB_SRAM_ADDR_CHECK_EN
            r_err    <= (w_state_nxt == S_ERR);
`else
            r_err    <= 1'b0;
`endif
            r_ce_n   <= ~w_sram_act;
            // oe_n and data_t come from disjoint state sets, so the pads
            // are never driven while the SRAM is driving them.
            r_oe_n   <= ~(w_state_nxt == S_READ);
            r_we_n   <= ~(w_state_nxt == S_WR_PULSE);
            r_data_t <= ~w_wr_phase;

            if (w_start_rd || w_start_wr) begin
                r_addr <= wb_adr_i[ADDR_WIDTH+1:2];
            end
            if (w_start_wr) begin
                r_data_o <= wb_dat_i;
            end

            if (w_start_rd) begin
                r_be_n <= 4'h0;
            end else if (w_start_wr) begin
                r_be_n <= ~wb_sel_i;
            end else if (!w_sram_act) begin
                r_be_n <= 4'hF;
            end

            if (w_rd_done) begin
                r_dat_o <= sram_data_i;
            end
        end
    end

    assign wb_dat_o    = r_dat_o;
    assign wb_ack_o    = r_ack;
    assign wb_err_o    = r_err;
    assign wb_rty_o    = 1'b0;
    assign sram_addr   = r_addr;
    assign sram_data_o = r_data_o;
    assign sram_data_t = r_data_t;
    assign sram_ce_n   = r_ce_n;
    assign sram_oe_n   = r_oe_n;
    assign sram_we_n   = r_we_n;
    assign sram_be_n   = r_be_n;

endmodule
`default_nettype wire

// File: tb/tb_wb_sram_slave.sv
`default_nettype none
// ============================================================================
//  Module   : tb_wb_sram_slave
//  Purpose  : Self-checking bench for wb_sram_slave with a behavioural
//             asynchronous SRAM and a response scoreboard.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_wb_sram_slave;

    localparam int AW  = 20;
    localparam int RDW = 2;
    localparam int WRW = 2;

    localparam int K_RD  = 0;
    localparam int K_WR  = 1;
    localparam int K_ERR = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wb_cyc_i = 1'b0;
    logic          wb_stb_i = 1'b0;
    logic          wb_we_i  = 1'b0;
    logic [31:0]   wb_adr_i = '0;
    logic [31:0]   wb_dat_i = '0;
    logic [3:0]    wb_sel_i = '0;
    logic [31:0]   wb_dat_o;
    logic          wb_ack_o;
    logic          wb_err_o;
    logic          wb_rty_o;
    logic [AW-1:0] sram_addr;
    logic [31:0]   sram_data_o;
    logic [31:0]   sram_data_i;
    logic          sram_data_t;
    logic          sram_ce_n;
    logic          sram_oe_n;
    logic          sram_we_n;
    logic [3:0]    sram_be_n;

    wb_sram_slave #(
        .ADDR_WIDTH (AW),
        .RD_WAIT    (RDW),
        .WR_WAIT    (WRW)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .wb_cyc_i    (wb_cyc_i),
        .wb_stb_i    (wb_stb_i),
        .wb_we_i     (wb_we_i),
        .wb_adr_i    (wb_adr_i),
        .wb_dat_i    (wb_dat_i),
        .wb_sel_i    (wb_sel_i),
        .wb_dat_o    (wb_dat_o),
        .wb_ack_o    (wb_ack_o),
        .wb_err_o    (wb_err_o),
        .wb_rty_o    (wb_rty_o),
        .sram_addr   (sram_addr),
        .sram_data_o (sram_data_o),
        .sram_data_i (sram_data_i),
        .sram_data_t (sram_data_t),
        .sram_ce_n   (sram_ce_n),
        .sram_oe_n   (sram_oe_n),
        .sram_we_n   (sram_we_n),
        .sram_be_n   (sram_be_n)
    );

    always #5 clk = ~clk;

    int cyc_cnt = 0;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    // ---------------- SRAM model (256 words, aliased) ----------------
    logic [31:0] mem [0:255];
    bit          mem_init_done = 1'b0;

    always @(posedge clk) begin
        if (!mem_init_done) begin
            for (int i = 0; i < 256; i++) mem[i] = 32'hA5A5_0000 | 32'(i);
            mem_init_done = 1'b1;
        end else if (!sram_ce_n && !sram_we_n) begin
            for (int b = 0; b < 4; b++)
                if (!sram_be_n[b]) mem[sram_addr[7:0]][b*8 +: 8] = sram_data_o[b*8 +: 8];
        end
    end

    assign sram_data_i = (!sram_ce_n && !sram_oe_n) ? mem[sram_addr[7:0]] : 32'h0;

    // ---------------- checking ----------------
    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    typedef struct {
        int            kind;
        logic [31:0]   dat;
        int            k;
        logic [AW-1:0] addr;
        logic [3:0]    be_n;
    } exp_t;

    exp_t sb[$];

    int            ce_cnt = 0;
    int            oe_cnt = 0;
    int            we_cnt = 0;
    int            we_first = 0;
    logic [AW-1:0] we_addr = '0;
    logic [3:0]    we_be = 4'hF;
    int            contention = 0;

    // Monitor: accumulates strobe activity per transaction and checks every
    // ack/err against the oldest expected response.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            ce_cnt = 0; oe_cnt = 0; we_cnt = 0;
        end else begin
            if (!sram_oe_n && !sram_data_t) contention++;
            if (!sram_ce_n) ce_cnt++;
            if (!sram_oe_n) oe_cnt++;
            if (!sram_we_n) begin
                if (we_cnt == 0) we_first = cyc_cnt;
                we_cnt++;
                we_addr = sram_addr;
                we_be   = sram_be_n;
            end
            if (wb_ack_o || wb_err_o) begin
                if (sb.size() == 0) begin
                    chk("unexpected_resp", {30'd0, wb_ack_o, wb_err_o}, 32'd0);
                end else begin
                    e = sb.pop_front();
                    if (e.kind == K_ERR) begin
                        chk("err_resp", {30'd0, wb_ack_o, wb_err_o}, 32'd1);
                        chk("err_cycle", cyc_cnt, e.k + 1);
                        chk("err_no_ce", ce_cnt, 0);
                    end else if (e.kind == K_RD) begin
                        chk("rd_resp", {30'd0, wb_ack_o, wb_err_o}, 32'd2);
                        chk("rd_cycle", cyc_cnt, e.k + RDW + 1);
                        chk("rd_data", wb_dat_o, e.dat);
                        chk("rd_addr", 32'(sram_addr), 32'(e.addr));
                        chk("rd_oe_cycles", oe_cnt, RDW);
                    end else begin
                        chk("wr_resp", {30'd0, wb_ack_o, wb_err_o}, 32'd2);
                        chk("wr_cycle", cyc_cnt, e.k + WRW + 3);
                        chk("wr_we_cycles", we_cnt, WRW);
                        chk("wr_we_first", we_first, e.k + 2);
                        chk("wr_addr", 32'(we_addr), 32'(e.addr));
                        chk("wr_be_n", 32'(we_be), 32'(e.be_n));
                    end
                end
            end
            if (sram_ce_n) begin
                ce_cnt = 0; oe_cnt = 0; we_cnt = 0;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic xfer(input bit sync, input bit we, input logic [31:0] adr,
                        input logic [31:0] dat, input logic [3:0] sel, input int kind,
                        input logic [31:0] exp_dat, input logic [AW-1:0] exp_addr,
                        input logic [3:0] exp_be);
        exp_t e;
        int   n;
        if (sync) begin
            @(posedge clk); #1;
        end
        e.kind = kind; e.dat = exp_dat; e.k = cyc_cnt; e.addr = exp_addr; e.be_n = exp_be;
        sb.push_back(e);
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we;
        wb_adr_i = adr;  wb_dat_i = dat;  wb_sel_i = sel;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(wb_ack_o || wb_err_o) && n < 40);
        if (!(wb_ack_o || wb_err_o)) chk("resp_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_ack"},    32'(wb_ack_o),    32'd0);
        chk({tag, "_err"},    32'(wb_err_o),    32'd0);
        chk({tag, "_rty"},    32'(wb_rty_o),    32'd0);
        chk({tag, "_dat_o"},  wb_dat_o,         32'd0);
        chk({tag, "_ce_n"},   32'(sram_ce_n),   32'd1);
        chk({tag, "_oe_n"},   32'(sram_oe_n),   32'd1);
        chk({tag, "_we_n"},   32'(sram_we_n),   32'd1);
        chk({tag, "_be_n"},   32'(sram_be_n),   32'hF);
        chk({tag, "_data_t"}, 32'(sram_data_t), 32'd1);
        chk({tag, "_addr"},   32'(sram_addr),   32'd0);
        chk({tag, "_data_o"}, sram_data_o,      32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk_reset_vals("rst0");
        rst = 1'b0;

        // word write, word read
        xfer(1, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, K_WR, 32'h0, 20'd4, 4'h0);
        xfer(1, 1'b0, 32'h0000_0010, 32'h0, 4'hF, K_RD, 32'hDEAD_BEEF, 20'd4, 4'h0);

        // byte write to lane 2, then read back the merged word
        xfer(1, 1'b1, 32'h0000_0012, 32'h00AB_0000, 4'b0100, K_WR, 32'h0, 20'd4, 4'b1011);
        xfer(1, 1'b0, 32'h0000_0010, 32'h0, 4'hF, K_RD, 32'hDEAB_BEEF, 20'd4, 4'h0);

        // abort a read in its first cycle, then write straight away
        @(posedge clk); #1;
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = 32'h10;
        @(posedge clk); #1;
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        @(negedge clk);
        chk("abort_oe_c1", 32'(sram_oe_n), 32'd0);
        @(posedge clk); #1;
        chk("abort_ce_c2", 32'(sram_ce_n), 32'd1);
        chk("abort_oe_c2", 32'(sram_oe_n), 32'd1);
        chk("abort_ack_c2", 32'(wb_ack_o), 32'd0);
        xfer(0, 1'b1, 32'h0000_0020, 32'h1234_5678, 4'hF, K_WR, 32'h0, 20'd8, 4'h0);
        xfer(1, 1'b0, 32'h0000_0020, 32'h0, 4'hF, K_RD, 32'h1234_5678, 20'd8, 4'h0);

        // empty byte mask: full sequence, no lanes written, read data held
        xfer(1, 1'b1, 32'h0000_0020, 32'hFFFF_FFFF, 4'h0, K_WR, 32'h0, 20'd8, 4'hF);
        chk("dat_o_hold_after_wr", wb_dat_o, 32'h1234_5678);
        xfer(1, 1'b0, 32'h0000_0020, 32'h0, 4'hF, K_RD, 32'h1234_5678, 20'd8, 4'h0);

        // out-of-range address
`ifdef WB_SRAM_ADDR_CHECK_EN
        xfer(1, 1'b0, 32'h0040_0000, 32'h0, 4'hF, K_ERR, 32'h0, 20'd0, 4'hF);
        @(negedge clk);
        chk("err_single_pulse", 32'(wb_err_o), 32'd0);
`else
        xfer(1, 1'b0, 32'h0040_0000, 32'h0, 4'hF, K_RD, 32'hA5A5_0000, 20'd0, 4'h0);
`endif

        // asynchronous reset in the middle of the write pulse
        @(posedge clk); #1;
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1;
        wb_adr_i = 32'h30; wb_dat_i = 32'hCAFE_F00D; wb_sel_i = 4'hF;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("pulse_we_low", 32'(sram_we_n), 32'd0);
        #2 rst = 1'b1;
        #1;
        chk("arst_we_n", 32'(sram_we_n), 32'd1);
        chk("arst_ce_n", 32'(sram_ce_n), 32'd1);
        chk("arst_data_t", 32'(sram_data_t), 32'd1);
        chk("arst_ack", 32'(wb_ack_o), 32'd0);
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_vals("rst1");

        // recovery after reset
        xfer(1, 1'b0, 32'h0000_0010, 32'h0, 4'hF, K_RD, 32'hDEAB_BEEF, 20'd4, 4'h0);

        repeat (3) @(posedge clk);
        #1;
        chk("no_contention", 32'(contention), 32'd0);
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
